// File: rtl/core_config_pkg.sv
// Shared core types for the multiply path: operation encoding, sequencer states
// and the op-to-signedness/half-select decode.
// Pure declarations; no logic state.
package core_config_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } mul_ctrl_state_t;

  // Returns {signed_a, signed_b, sel_high}. MUL uses the signed/signed encoding
  // because the low half of the product does not depend on signedness.
  function automatic logic [2:0] mul_decode(input mul_op_t op);
    logic [2:0] d;
    case (op)
      OP_MUL:    d = 3'b110;
      OP_MULH:   d = 3'b111;
      OP_MULHSU: d = 3'b101;
      default:   d = 3'b001;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mul_ctrl_result_cache.sv
// One-entry cache of the last full product, keyed by operands and signedness.
// Lookup is combinational; a fill lands on the clock edge after it is presented.
// No backpressure: fills are always accepted and replace the single entry.
module mul_result_cache #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fill,
  input  logic [XLEN-1:0] fill_a,
  input  logic [XLEN-1:0] fill_b,
  input  logic            fill_sa,
  input  logic            fill_sb,
  input  logic [XLEN-1:0] fill_lo,
  input  logic [XLEN-1:0] fill_hi,
  input  logic [XLEN-1:0] lk_a,
  input  logic [XLEN-1:0] lk_b,
  input  logic            lk_sa,
  input  logic            lk_sb,
  input  logic            lk_sel_high,
  output logic            hit,
  output logic [XLEN-1:0] hit_data
);

  logic            valid_q;
  logic [XLEN-1:0] key_a_q;
  logic [XLEN-1:0] key_b_q;
  logic            key_sa_q;
  logic            key_sb_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] hi_q;

  // Capture the completed product and its key; the entry never goes stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      key_a_q  <= '0;
      key_b_q  <= '0;
      key_sa_q <= 1'b0;
      key_sb_q <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
    end else if (fill) begin
      valid_q  <= 1'b1;
      key_a_q  <= fill_a;
      key_b_q  <= fill_b;
      key_sa_q <= fill_sa;
      key_sb_q <= fill_sb;
      lo_q     <= fill_lo;
      hi_q     <= fill_hi;
    end
  end

  // Low half is signedness-independent, so only high-half lookups compare flags.
  always_comb begin
    hit      = 1'b0;
    hit_data = lk_sel_high ? hi_q : lo_q;
    if (valid_q && (key_a_q == lk_a) && (key_b_q == lk_b)) begin
      hit = !lk_sel_high || ((key_sa_q == lk_sa) && (key_sb_q == lk_sb));
    end
  end

endmodule

// File: rtl/mul_ctrl.sv
// Sequences RV32M multiply requests onto the iterative Booth multiplier.
// Accept to resp_valid: multiplier latency + 2 cycles on a miss, 1 cycle on a cache hit.
// One request in flight; req_ready drops outside IDLE, resp_valid holds until resp_ready or flush.
module mul_ctrl #(
  parameter int XLEN     = core_config_pkg::XLEN,
  parameter int TAG_W    = 5,
  parameter int REUSE_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [XLEN-1:0]  req_rs1,
  input  logic [XLEN-1:0]  req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             mul_start,
  output logic [XLEN-1:0]  mul_multiplicand,
  output logic [XLEN-1:0]  mul_multiplier,
  output logic             mul_signed_a,
  output logic             mul_signed_b,
  input  logic [XLEN-1:0]  mul_product_low,
  input  logic [XLEN-1:0]  mul_product_high,
  input  logic             mul_done,
  output logic             busy,
  output logic [31:0]      stat_issued,
  output logic [31:0]      stat_reused
);

  import core_config_pkg::*;

  mul_ctrl_state_t state, state_nxt;

  logic             accept;
  logic [2:0]       req_dec;
  logic             cache_hit;
  logic [XLEN-1:0]  cache_data;

  logic [XLEN-1:0]  a_q;
  logic [XLEN-1:0]  b_q;
  logic             sa_q;
  logic             sb_q;
  logic             sel_high_q;
  logic [TAG_W-1:0] tag_q;
  logic             killed_q;
  logic [XLEN-1:0]  resp_data_q;
  logic [31:0]      issued_q;
  logic [31:0]      reused_q;

  assign req_dec    = mul_decode(mul_op_t'(req_op));
  assign req_ready  = (state == IDLE) && !flush;
  assign accept     = req_valid && req_ready;
  assign mul_start  = (state == ISSUE) && !flush;
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

  assign mul_multiplicand = a_q;
  assign mul_multiplier   = b_q;
  assign mul_signed_a     = sa_q;
  assign mul_signed_b     = sb_q;
  assign resp_data        = resp_data_q;
  assign resp_tag         = tag_q;
  assign stat_issued      = issued_q;
  assign stat_reused      = reused_q;

  generate
    if (REUSE_EN != 0) begin : g_cache
      mul_result_cache #(.XLEN(XLEN)) u_cache (
        .clk         (clk),
        .rst_n       (rst_n),
        .fill        ((state == WAIT) && mul_done),
        .fill_a      (a_q),
        .fill_b      (b_q),
        .fill_sa     (sa_q),
        .fill_sb     (sb_q),
        .fill_lo     (mul_product_low),
        .fill_hi     (mul_product_high),
        .lk_a        (req_rs1),
        .lk_b        (req_rs2),
        .lk_sa       (req_dec[2]),
        .lk_sb       (req_dec[1]),
        .lk_sel_high (req_dec[0]),
        .hit         (cache_hit),
        .hit_data    (cache_data)
      );
    end else begin : g_no_cache
      assign cache_hit  = 1'b0;
      assign cache_data = '0;
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state; a flush arriving with mul_done counts as a kill.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = cache_hit ? RESP : ISSUE;
      ISSUE: state_nxt = flush ? IDLE : WAIT;
      WAIT:  if (mul_done) state_nxt = (killed_q || flush) ? IDLE : RESP;
      RESP:  if (flush || resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand/tag capture, response data, kill tracking and statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      sel_high_q  <= 1'b0;
      tag_q       <= '0;
      killed_q    <= 1'b0;
      resp_data_q <= '0;
      issued_q    <= '0;
      reused_q    <= '0;
    end else begin
      if (accept) begin
        a_q        <= req_rs1;
        b_q        <= req_rs2;
        sa_q       <= req_dec[2];
        sb_q       <= req_dec[1];
        sel_high_q <= req_dec[0];
        tag_q      <= req_tag;
        if (cache_hit) begin
          resp_data_q <= cache_data;
          reused_q    <= reused_q + 32'd1;
        end
      end
      if (mul_start) issued_q <= issued_q + 32'd1;
      if (state == WAIT) begin
        if (mul_done) begin
          killed_q <= 1'b0;
          if (!(killed_q || flush))
            resp_data_q <= sel_high_q ? mul_product_high : mul_product_low;
        end else if (flush) begin
          killed_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed bench for mul_ctrl with a fixed-latency behavioural multiplier.
module tb_mul_ctrl;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_rs1 = '0;
  logic [31:0] req_rs2 = '0;
  logic [4:0]  req_tag = '0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic [4:0]  resp_tag;
  logic        mul_start;
  logic [31:0] mul_multiplicand;
  logic [31:0] mul_multiplier;
  logic        mul_signed_a;
  logic        mul_signed_b;
  logic [31:0] mul_product_low;
  logic [31:0] mul_product_high;
  logic        mul_done;
  logic        busy;
  logic [31:0] stat_issued;
  logic [31:0] stat_reused;

  logic        model_done;
  logic        inject_done = 1'b0;
  logic [63:0] model_prod;
  int          model_cnt;
  int          start_cnt = 0;
  int          vectors = 0;
  int          miscompares = 0;

  assign mul_done         = model_done | inject_done;
  assign mul_product_low  = model_prod[31:0];
  assign mul_product_high = model_prod[63:32];

  always #5 clk = ~clk;

  mul_ctrl #(.XLEN(32), .TAG_W(5), .REUSE_EN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_tag(resp_tag),
    .mul_start(mul_start), .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
    .mul_signed_a(mul_signed_a), .mul_signed_b(mul_signed_b),
    .mul_product_low(mul_product_low), .mul_product_high(mul_product_high), .mul_done(mul_done),
    .busy(busy), .stat_issued(stat_issued), .stat_reused(stat_reused)
  );

  // Behavioural multiplier: samples operands on the start edge, pulses done LAT edges later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_cnt  <= 0;
      model_done <= 1'b0;
      model_prod <= '0;
    end else begin
      model_done <= 1'b0;
      if (mul_start) begin
        model_prod <= (mul_signed_a ? {{32{mul_multiplicand[31]}}, mul_multiplicand} : {32'b0, mul_multiplicand})
                    * (mul_signed_b ? {{32{mul_multiplier[31]}}, mul_multiplier} : {32'b0, mul_multiplier});
        model_cnt  <= LAT;
      end else if (model_cnt != 0) begin
        model_cnt <= model_cnt - 1;
        if (model_cnt == 1) model_done <= 1'b1;
      end
    end
  end

  always @(posedge clk) if (mul_start) start_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents a request and returns #1 after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_tag = tag;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("accept_timeout", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    while (!resp_valid && n < 100) begin @(negedge clk); n++; end
    chk("resp_timeout", 32'(resp_valid), 32'd1);
  endtask

  task automatic retire();
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
    chk("retire_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    int bad;
    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(mul_start), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_stat_issued", stat_issued, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    // MULHU -1 x -1 (unsigned): high half 0xFFFFFFFE.
    send(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1);
    chk("mulhu_sa", 32'(mul_signed_a), 32'd0);
    chk("mulhu_sb", 32'(mul_signed_b), 32'd0);
    chk("mulhu_ready_low", 32'(req_ready), 32'd0);
    wait_resp();
    chk("mulhu_data", resp_data, 32'hFFFFFFFE);
    chk("mulhu_tag", 32'(resp_tag), 32'd1);
    chk("mulhu_starts", start_cnt, 32'd1);
    chk("mulhu_issued", stat_issued, 32'd1);
    retire();

    // MUL on the same pair: cache hit, response the cycle after accept.
    send(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2);
    chk("hit_resp_valid", 32'(resp_valid), 32'd1);
    chk("hit_data", resp_data, 32'h00000001);
    chk("hit_tag", 32'(resp_tag), 32'd2);
    chk("hit_starts", start_cnt, 32'd1);
    chk("hit_reused", stat_reused, 32'd1);
    retire();

    // MULH on the same pair: signedness differs, must issue. (-1)*(-1) = 1.
    send(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3);
    chk("mulh_miss_busy_issue", 32'(mul_start), 32'd1);
    wait_resp();
    chk("mulh_miss_data", resp_data, 32'h00000000);
    chk("mulh_miss_starts", start_cnt, 32'd2);
    chk("mulh_miss_issued", stat_issued, 32'd2);
    retire();

    // MULH min x min = 2^62.
    send(2'b01, 32'h80000000, 32'h80000000, 5'd4);
    wait_resp();
    chk("mulh_min_data", resp_data, 32'h40000000);
    retire();

    // MULHSU -1 x 2 = -2.
    send(2'b10, 32'hFFFFFFFF, 32'h00000002, 5'd5);
    chk("mulhsu_sa", 32'(mul_signed_a), 32'd1);
    chk("mulhsu_sb", 32'(mul_signed_b), 32'd0);
    wait_resp();
    chk("mulhsu_data", resp_data, 32'hFFFFFFFF);
    chk("mulhsu_starts", start_cnt, 32'd4);
    retire();

    // Flush three cycles into WAIT: result dropped, multiplier drained, cache still fills.
    send(2'b00, 32'h12345678, 32'h00000010, 5'd6);
    @(posedge clk); #1;
    chk("flushw_in_wait", 32'(busy), 32'd1);
    @(posedge clk); @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bad = 0; n = 0;
    while (!mul_done && n < 50) begin
      if (req_ready || resp_valid) bad++;
      @(negedge clk); n++;
    end
    chk("flushw_done_seen", 32'(mul_done), 32'd1);
    chk("flushw_no_ready_no_resp", bad, 32'd0);
    chk("flushw_ready_at_done", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("flushw_ready_after", 32'(req_ready), 32'd1);
    chk("flushw_no_resp", 32'(resp_valid), 32'd0);
    send(2'b00, 32'h12345678, 32'h00000010, 5'd8);
    chk("flushw_hit_valid", 32'(resp_valid), 32'd1);
    chk("flushw_hit_data", resp_data, 32'h23456780);
    chk("flushw_hit_starts", start_cnt, 32'd5);
    chk("flushw_hit_reused", stat_reused, 32'd2);
    retire();

    // Backpressure: response held five cycles unchanged.
    send(2'b11, 32'h00010000, 32'h00010000, 5'd7);
    wait_resp();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_data", resp_data, 32'h00000001);
      chk("bp_tag", 32'(resp_tag), 32'd7);
      @(negedge clk);
    end
    retire();

    // Flush in ISSUE: no start, back to IDLE.
    send(2'b00, 32'h00000003, 32'h00000005, 5'd9);
    flush = 1'b1;
    #1;
    chk("flushi_no_start", 32'(mul_start), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flushi_idle", 32'(busy), 32'd0);
    chk("flushi_starts", start_cnt, 32'd6);
    chk("flushi_issued", stat_issued, 32'd6);

    // Reset mid-WAIT, then a stray done pulse.
    send(2'b00, 32'h00000007, 32'h00000009, 5'd10);
    @(posedge clk); @(posedge clk); #1;
    chk("rstw_in_wait", 32'(busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstw_busy", 32'(busy), 32'd0);
    chk("rstw_resp_valid", 32'(resp_valid), 32'd0);
    chk("rstw_start", 32'(mul_start), 32'd0);
    chk("rstw_mcand", mul_multiplicand, 32'd0);
    chk("rstw_issued", stat_issued, 32'd0);
    chk("rstw_reused", stat_reused, 32'd0);
    chk("rstw_tag", 32'(resp_tag), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    inject_done = 1'b1;
    @(negedge clk);
    inject_done = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid || busy) bad++;
      @(negedge clk);
    end
    chk("stray_done_ignored", bad, 32'd0);
    // Cache was invalidated: a previously cached pair must issue again.
    send(2'b11, 32'h00010000, 32'h00010000, 5'd11);
    chk("rstw_cache_miss", 32'(mul_start), 32'd1);
    wait_resp();
    chk("rstw_miss_data", resp_data, 32'h00000001);
    chk("rstw_miss_issued", stat_issued, 32'd1);
    chk("rstw_miss_reused", stat_reused, 32'd0);
    retire();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
